// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - per-frame pong ball mover: serve/move/scored FSM, wall bounce, paddle deflection, goals.
// Optional BALL_SPEEDUP_EN: each paddle hit bumps the latched x speed by one (saturating).
module ball_motion #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int VEL_W       = 6,
   parameter int BALL_W      = 8,
   parameter int CENTER_X    = 310,
   parameter int CENTER_Y    = 240,
   parameter int PAD_LX      = 16,
   parameter int PAD_RX      = 616,
   parameter int PAD_W       = 8,
   parameter int HOLD_FRAMES = 60
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             serve,
   input  logic             serve_dir,
   input  logic [VEL_W-1:0] speed_x,
   input  logic [VEL_W-1:0] speed_y,
   input  logic [Y_W-1:0]   pad_ly,
   input  logic [Y_W-1:0]   pad_ry,
   input  logic [Y_W-1:0]   pad_h,
   output logic [X_W-1:0]   ball_x,
   output logic [Y_W-1:0]   ball_y,
   output logic             dir_x,
   output logic             dir_y,
   output logic             goal_l,
   output logic             goal_r,
   output logic             busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_SCORED} state_t;

   localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

   localparam logic [X_W-1:0] X_HOME = X_W'(CENTER_X - (BALL_W >> 1));
   localparam logic [Y_W-1:0] Y_HOME = Y_W'(CENTER_Y - (BALL_W >> 1));
   localparam logic [X_W-1:0] X_LHIT = X_W'(PAD_LX + PAD_W);
   localparam logic [X_W-1:0] X_RHIT = X_W'(PAD_RX - BALL_W);
   localparam logic [Y_W-1:0] Y_BOT  = Y_W'(SCREEN_H - BALL_W);

   localparam logic signed [X_W+1:0] BW_X   = (X_W+2)'(BALL_W);
   localparam logic signed [X_W+1:0] L_EDGE = (X_W+2)'(PAD_LX + PAD_W);
   localparam logic signed [X_W+1:0] R_EDGE = (X_W+2)'(PAD_RX);
   localparam logic signed [X_W+1:0] SW_X   = (X_W+2)'(SCREEN_W);
   localparam logic signed [Y_W+1:0] BW_Y   = (Y_W+2)'(BALL_W);
   localparam logic signed [Y_W+1:0] SH_Y   = (Y_W+2)'(SCREEN_H);

   state_t             state_q, state_d;
   logic [X_W-1:0]     x_q, x_d;
   logic [Y_W-1:0]     y_q, y_d;
   logic               dx_q, dx_d;
   logic               dy_q, dy_d;
   logic [VEL_W-1:0]   sx_q, sx_d;
   logic [VEL_W-1:0]   sy_q, sy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               gl_q, gl_d;
   logic               gr_q, gr_d;

   logic signed [X_W+1:0] x_s, sx_e, nx;
   logic signed [Y_W+1:0] sy_e, ny, pl_s, pr_s, ph_s;
   logic                  hit_l, hit_r;

   // Signed, two-bit-wider copies so overshoot past either edge never wraps.
   assign x_s  = $signed({2'b00, x_q});
   assign sx_e = $signed({{(X_W+2-VEL_W){1'b0}}, sx_q});
   assign sy_e = $signed({{(Y_W+2-VEL_W){1'b0}}, sy_q});
   assign pl_s = $signed({2'b00, pad_ly});
   assign pr_s = $signed({2'b00, pad_ry});
   assign ph_s = $signed({2'b00, pad_h});
   assign nx   = dx_q ? x_s + sx_e : x_s - sx_e;
   assign ny   = dy_q ? $signed({2'b00, y_q}) + sy_e : $signed({2'b00, y_q}) - sy_e;

   assign hit_l = !dx_q && (nx <= L_EDGE) && (x_s >= L_EDGE)
                  && (ny + BW_Y > pl_s) && (ny < pl_s + ph_s);
   assign hit_r = dx_q && (nx + BW_X >= R_EDGE) && (x_s + BW_X <= R_EDGE)
                  && (ny + BW_Y > pr_s) && (ny < pr_s + ph_s);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      cnt_d   = cnt_q;
      gl_d    = 1'b0;
      gr_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            x_d = X_HOME;
            y_d = Y_HOME;
            if (serve) begin
               sx_d    = speed_x;
               sy_d    = speed_y;
               dx_d    = serve_dir;
               dy_d    = 1'b1;
               state_d = ST_MOVE;
            end
         end
         ST_MOVE: begin
            if (frame_tick) begin
               if (!hit_l && !hit_r && (nx < 0)) begin
                  gl_d    = 1'b1;
                  state_d = ST_SCORED;
               end else if (!hit_l && !hit_r && (nx + BW_X > SW_X)) begin
                  gr_d    = 1'b1;
                  state_d = ST_SCORED;
               end else begin
                  if (hit_l) begin
                     x_d  = X_LHIT;
                     dx_d = 1'b1;
                  end else if (hit_r) begin
                     x_d  = X_RHIT;
                     dx_d = 1'b0;
                  end else begin
                     x_d = nx[X_W-1:0];
                  end
`ifdef BALL_SPEEDUP_EN
                  if ((hit_l || hit_r) && (sx_q != {VEL_W{1'b1}})) begin
                     sx_d = sx_q + 1'b1;
                  end
`endif
                  if (ny < 0) begin
                     y_d  = '0;
                     dy_d = 1'b1;
                  end else if (ny + BW_Y > SH_Y) begin
                     y_d  = Y_BOT;
                     dy_d = 1'b0;
                  end else begin
                     y_d = ny[Y_W-1:0];
                  end
               end
            end
         end
         ST_SCORED: begin
            if (frame_tick) begin
               if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
                  cnt_d   = '0;
                  x_d     = X_HOME;
                  y_d     = Y_HOME;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= X_HOME;
         y_q     <= Y_HOME;
         dx_q    <= 1'b0;
         dy_q    <= 1'b1;
         sx_q    <= '0;
         sy_q    <= '0;
         cnt_q   <= '0;
         gl_q    <= 1'b0;
         gr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cnt_q   <= cnt_d;
         gl_q    <= gl_d;
         gr_q    <= gr_d;
      end
   end

   assign ball_x = x_q;
   assign ball_y = y_q;
   assign dir_x  = dx_q;
   assign dir_y  = dy_q;
   assign goal_l = gl_q;
   assign goal_r = gr_q;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - randomized and directed checks of ball_motion against an integer playfield model.
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       reset, frame_tick, serve, serve_dir;
   logic [5:0] speed_x, speed_y;
   logic [8:0] pad_ly, pad_ry, pad_h;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       dir_x, dir_y, goal_l, goal_r, busy;

   int checks = 0;
   int errors = 0;

   // Playfield model: plain integers, mode 0 idle, 1 rally, 2 post-goal hold.
   int m_mode, m_x, m_y, m_dx, m_dy, m_sx, m_sy, m_hold, m_gl, m_gr;

   always #5 clk = ~clk;

   ball_motion dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
      .serve_dir(serve_dir), .speed_x(speed_x), .speed_y(speed_y),
      .pad_ly(pad_ly), .pad_ry(pad_ry), .pad_h(pad_h),
      .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
      .goal_l(goal_l), .goal_r(goal_r), .busy(busy)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_x = 306; m_y = 236; m_dx = 0; m_dy = 1;
      m_sx = 0; m_sy = 0; m_hold = 0; m_gl = 0; m_gr = 0;
   endtask

   task automatic model_step();
      int nx, ny, top, bot, over_l, over_r;
      bit lh, rh;
      m_gl = 0;
      m_gr = 0;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_mode == 0) begin
         m_x = 306; m_y = 236;
         if (serve) begin
            m_sx = speed_x; m_sy = speed_y; m_dx = serve_dir; m_dy = 1; m_mode = 1;
         end
      end else if (m_mode == 1 && frame_tick) begin
         nx = m_dx ? m_x + m_sx : m_x - m_sx;
         ny = m_dy ? m_y + m_sy : m_y - m_sy;
         top = ny; bot = ny + 8;
         over_l = (bot > int'(pad_ly)) && (top < int'(pad_ly) + int'(pad_h));
         over_r = (bot > int'(pad_ry)) && (top < int'(pad_ry) + int'(pad_h));
         lh = (m_dx == 0) && nx <= 24 && m_x >= 24 && over_l;
         rh = (m_dx == 1) && nx + 8 >= 616 && m_x + 8 <= 616 && over_r;
         if (!lh && !rh && nx < 0) begin
            m_gl = 1; m_mode = 2;
         end else if (!lh && !rh && nx + 8 > 640) begin
            m_gr = 1; m_mode = 2;
         end else begin
            if (lh) begin m_x = 24; m_dx = 1; end
            else if (rh) begin m_x = 608; m_dx = 0; end
            else m_x = nx;
`ifdef BALL_SPEEDUP_EN
            if (lh || rh) m_sx = (m_sx + 1 > 63) ? 63 : m_sx + 1;
`endif
            if (ny < 0) begin m_y = 0; m_dy = 1; end
            else if (ny + 8 > 480) begin m_y = 472; m_dy = 0; end
            else m_y = ny;
         end
      end else if (m_mode == 2 && frame_tick) begin
         m_hold++;
         if (m_hold == 60) begin
            m_hold = 0; m_mode = 0; m_x = 306; m_y = 236;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_eq("ball_x", int'(ball_x), m_x);
      check_eq("ball_y", int'(ball_y), m_y);
      check_eq("dir_x", int'(dir_x), m_dx);
      check_eq("dir_y", int'(dir_y), m_dy);
      check_eq("goal_l", int'(goal_l), m_gl);
      check_eq("goal_r", int'(goal_r), m_gr);
      check_eq("busy", int'(busy), int'(m_mode != 0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic do_serve(input logic dir, input int sx, input int sy);
      serve = 1'b1; serve_dir = dir; speed_x = 6'(sx); speed_y = 6'(sy);
      step();
      serve = 1'b0;
   endtask

   task automatic ticks(input int n);
      frame_tick = 1'b1;
      repeat (n) step();
      frame_tick = 1'b0;
   endtask

   // Runs a left-bound rally into the left goal; returns 1 when goal_l was a single-cycle pulse.
   task automatic run_to_left_goal(output bit ok);
      bit seen;
      int budget;
      seen = 0; ok = 0; budget = 0;
      while (!seen && budget < 200) begin
         frame_tick = 1'b1; step(); frame_tick = 1'b0;
         seen = goal_l;
         budget++;
      end
      check_eq("left_goal_within_budget", int'(seen), 1);
      step();
      ok = seen && !goal_l;
   endtask

   initial begin
      bit ok;
      reset = 1'b0; frame_tick = 1'b0; serve = 1'b0; serve_dir = 1'b0;
      speed_x = '0; speed_y = '0; pad_ly = 9'd200; pad_ry = 9'd200; pad_h = 9'd64;
      model_reset();

      do_reset();
      check_eq("rst_ball_x", int'(ball_x), 306);
      check_eq("rst_ball_y", int'(ball_y), 236);
      check_eq("rst_dir_x", int'(dir_x), 0);
      check_eq("rst_busy", int'(busy), 0);

      // serve coinciding with a tick: MOVE entered but no motion that step
      frame_tick = 1'b1;
      do_serve(1'b1, 4, 2);
      frame_tick = 1'b0;
      check_eq("serve_tick_x", int'(ball_x), 306);
      check_eq("serve_busy", int'(busy), 1);
      ticks(3);
      check_eq("serve3_x", int'(ball_x), 318);
      check_eq("serve3_y", int'(ball_y), 242);

      // vertical bounce: zero x speed, sy=3 reaches y=1 moving up after 236 ticks
      do_reset();
      do_serve(1'b0, 0, 3);
      ticks(236);
      check_eq("pre_top_y", int'(ball_y), 1);
      check_eq("pre_top_dir_y", int'(dir_y), 0);
      ticks(1);
      check_eq("top_y", int'(ball_y), 0);
      check_eq("top_dir_y", int'(dir_y), 1);
      ticks(1);
      check_eq("after_top_y", int'(ball_y), 3);

      // left paddle: 46 ticks to x=30, then nx=24 deflects
      do_reset();
      pad_ly = 9'd200; pad_h = 9'd64;
      do_serve(1'b0, 6, 0);
      ticks(46);
      check_eq("pre_hit_x", int'(ball_x), 30);
      ticks(1);
      check_eq("hit_x", int'(ball_x), 24);
      check_eq("hit_dir_x", int'(dir_x), 1);
      check_eq("hit_no_goal", int'(goal_l), 0);

      // left goal with a missing paddle, then the 60-tick hold
      do_reset();
      pad_ly = 9'd0;
      do_serve(1'b0, 6, 0);
      run_to_left_goal(ok);
      check_eq("goal_l_one_cycle", int'(ok), 1);
      check_eq("scored_busy", int'(busy), 1);
      ticks(59);
      check_eq("hold59_busy", int'(busy), 1);
      ticks(1);
      check_eq("hold60_busy", int'(busy), 0);
      check_eq("hold60_x", int'(ball_x), 306);
      check_eq("hold60_y", int'(ball_y), 236);

      // reset in the middle of the hold clears the counter
      do_serve(1'b0, 6, 0);
      run_to_left_goal(ok);
      ticks(20);
      do_reset();
      check_eq("mid_hold_rst_busy", int'(busy), 0);
      do_serve(1'b0, 6, 0);
      run_to_left_goal(ok);
      ticks(59);
      check_eq("fresh_hold_busy", int'(busy), 1);
      ticks(1);
      check_eq("fresh_hold_done", int'(busy), 0);

      // long random play with random paddles and occasional resets
      pad_h = 9'd150;
      for (int i = 0; i < 15000; i++) begin
         reset      = ($urandom_range(0, 999) != 0);
         frame_tick = 1'($urandom_range(0, 1));
         serve      = ($urandom_range(0, 19) == 0);
         serve_dir  = 1'($urandom_range(0, 1));
         speed_x    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(58, 63))
                                                  : 6'($urandom_range(0, 15));
         speed_y    = 6'($urandom_range(0, 12));
         pad_ly     = 9'($urandom_range(0, 470));
         pad_ry     = 9'($urandom_range(0, 470));
         pad_h      = 9'($urandom_range(0, 300));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Per-frame ball position engine for the pong playfield; next generation of the single-step ball mover.
- Owns ball position and direction internally. Handles top/bottom wall bounce, left/right paddle deflection and goal detection.
- Runs a serve/move/scored state machine. Feeds the renderer (ball_x/ball_y) and the score keeper (goal pulses).

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- VEL_W, 6, speed magnitude width
- BALL_W, 8, ball side length (square)
- CENTER_X, 310, serve reference x; ball left edge = CENTER_X-(BALL_W>>1)
- CENTER_Y, 240, serve reference y; ball top edge = CENTER_Y-(BALL_W>>1)
- PAD_LX, 16, left paddle left edge x
- PAD_RX, 616, right paddle left edge x
- PAD_W, 8, paddle width
- HOLD_FRAMES, 60, frames spent in SCORED before returning to IDLE

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge)
- frame_tick  in  1  one-cycle pulse, advance ball one step
- serve  in  1  start a rally (honoured in IDLE only)
- serve_dir  in  1  initial x direction: 0 = left, 1 = right
- speed_x  in  VEL_W  x speed magnitude, latched at serve
- speed_y  in  VEL_W  y speed magnitude, latched at serve
- pad_ly  in  Y_W  left paddle top y
- pad_ry  in  Y_W  right paddle top y
- pad_h  in  Y_W  paddle height (both paddles)
- ball_x  out  X_W  ball left edge
- ball_y  out  Y_W  ball top edge
- dir_x  out  1  0 = moving left, 1 = moving right
- dir_y  out  1  0 = moving up, 1 = moving down
- goal_l  out  1  one-cycle pulse: ball exited left edge (right player scores)
- goal_r  out  1  one-cycle pulse: ball exited right edge (left player scores)
- busy  out  1  high in MOVE or SCORED

Behaviour:
- Reset (reset==0 at clk edge):
  - ball_x = CENTER_X-(BALL_W>>1) (306); ball_y = CENTER_Y-(BALL_W>>1) (236).
  - dir_x = 0, dir_y = 1; goal_l = goal_r = 0; busy = 0.
  - State = IDLE; hold counter = 0; latched speeds = 0.
  - Reset overrides everything, including mid-rally and mid-hold.
- IDLE:
  - Ball held at the centre values.
  - On serve: latch speed_x/speed_y; dir_x = serve_dir; dir_y = 1; go to MOVE.
  - No movement occurs in the serve cycle, even if frame_tick is also high.
- MOVE, per frame_tick (position updates the cycle after the tick, i.e. registered with 1-cycle latency):
  - Arithmetic: signed, X_W+2 / Y_W+2 bits, no wrap. nx = x ± sx, ny = y ± sy.
  - Top wall: ny < 0 -> y = 0, dir_y = 1.
  - Bottom wall: ny+BALL_W > SCREEN_H -> y = SCREEN_H-BALL_W, dir_y = 0.
  - Left paddle, when dir_x = 0:
    - Hit when nx <= PAD_LX+PAD_W and x >= PAD_LX+PAD_W, and y-overlap holds: ny+BALL_W > pad_ly and ny < pad_ly+pad_h.
    - On hit: x = PAD_LX+PAD_W, dir_x = 1.
  - Right paddle (mirror), when dir_x = 1:
    - Hit when nx+BALL_W >= PAD_RX and x+BALL_W <= PAD_RX, with the same y-overlap test against pad_ry.
    - On hit: x = PAD_RX-BALL_W, dir_x = 0.
  - Goals:
    - nx < 0 with no hit -> goal_l pulse, go to SCORED.
    - nx+BALL_W > SCREEN_W with no hit -> goal_r pulse, go to SCORED.
    - Position freezes at its last in-range value.
  - Ordering and concurrency:
    - Wall and paddle/goal checks are evaluated independently in the same step (corner hits flip both directions).
    - Paddle hit takes precedence over goal.
  - Zero speed is legal: ball stays stationary.
  - serve is ignored in MOVE and SCORED.
- SCORED:
  - Hold counter increments per frame_tick.
  - When the count reaches HOLD_FRAMES: recentre ball, clear counter, go to IDLE.
- Outputs are registered. Goal pulses are exactly one cycle, asserted the cycle after the causing tick.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - Each paddle hit increments latched x speed by 1, saturating at 2^VEL_W-1.
  - Reset or a new serve reloads speed from speed_x.
- Undefined: x speed is constant for the whole rally.

Test Plan:
- Reset and serve:
  - Hold reset=0 for 2 clocks -> ball_x=306, ball_y=236, dir_x=0, busy=0.
  - serve with serve_dir=1, sx=4, sy=2, then 3 ticks -> ball_x=318, ball_y=242.
- Top bounce:
  - Ball at y=1, dir_y=0, sy=3, tick -> y=0, dir_y=1.
  - Next tick -> y=3.
- Left paddle hit:
  - Setup: pad_ly=200, pad_h=64, ball x=28, y=220, dir_x=0, sx=6.
  - Tick -> x=24, dir_x=1, no goal.
- Left goal:
  - Same as paddle hit but pad_ly=0 (no overlap).
  - Ticks until nx<0 -> goal_l high exactly 1 cycle, busy=1.
  - After 60 further ticks -> IDLE, ball at (306,236), busy=0.
- Edge concurrency:
  - serve and frame_tick in the same IDLE cycle -> MOVE entered, position unchanged that step.
  - Reset asserted mid-SCORED -> IDLE, counter cleared.
- BALL_SPEEDUP_EN:
  - 3 paddle hits with sx=62 -> latched speed 63 (saturated).
  - Without the macro -> stays 62.
